// File: rtl/mbscore_intc_pkg.sv
// MBScore interrupt controller shared constants: config register map and
// FSM state encodings (legacy MBScore_const.v values kept bit-exact).
package mbscore_intc_pkg;

  typedef logic [1:0] intc_state_t;

  localparam intc_state_t ST_IDLE     = 2'd0;
  localparam intc_state_t ST_ISSUE    = 2'd1;
  localparam intc_state_t ST_WAIT_ACK = 2'd2;
  localparam intc_state_t ST_SERVICE  = 2'd3;

  localparam logic [1:0] INTC_ADDR_MASK = 2'd0;
  localparam logic [1:0] INTC_ADDR_PEND = 2'd1;
  localparam logic [1:0] INTC_ADDR_ID   = 2'd2;
  localparam logic [1:0] INTC_ADDR_STAT = 2'd3;

  localparam int unsigned INTC_CNT_W = 8;

endpackage

// File: rtl/mbscore_intc_if.sv
// MBScore interrupt controller config port: write strobe, address, write
// data and combinational read data.
interface mbscore_intc_if;

  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_rdata);

endinterface

// File: rtl/mbscore_intc_prio.sv
// Lowest-index priority encoder: bit 0 wins; valid when any request is set.
module mbscore_intc_prio #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan upward and keep the first set bit.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (req[i] && !valid) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbscore_intc.sv
// MBScore interrupt controller: synchronises IRQ lines, latches pending,
// masks and prioritises, then pulses set_intr at an instruction boundary and
// follows the RF int_en_n flag through entry and return.
// Build option: MBSCORE_INTC_EDGE_EN selects rising-edge detection of the
// synchronised lines; undefined gives level-sensitive pending.
module mbscore_intc
  import mbscore_intc_pkg::*;
#(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             int_en_n,
  input  logic             inst_boundary,
  output logic             set_intr,
  output logic [ID_W-1:0]  irq_vec,
  output logic             irq_active,
  mbscore_intc_if.slave    cfg
);

  logic [N_IRQ-1:0]      sync1, sync2, detect;
  logic [N_IRQ-1:0]      pending, mask, eligible, pend_clr;
  logic [ID_W-1:0]       win_id;
  logic                  win_valid;
  intc_state_t           state;
  logic [INTC_CNT_W-1:0] cnt, cnt_nx;
  logic                  timeout_flag, timeout_hit, issue_go;
  logic                  wr_mask, wr_pend, wr_stat;
  logic                  unused_wdata;

  assign unused_wdata = ^cfg.cfg_wdata;

  // Two-flop synchroniser on the asynchronous IRQ lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

`ifdef MBSCORE_INTC_EDGE_EN
  logic [N_IRQ-1:0] sync3;

  // Delayed copy of the synchronised lines for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync3 <= '0;
    else        sync3 <= sync2;
  end

  assign detect = sync2 & ~sync3;
`else
  assign detect = sync2;
`endif

  assign eligible = pending & mask;

  mbscore_intc_prio #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (eligible),
    .id    (win_id),
    .valid (win_valid)
  );

  assign wr_mask     = cfg.cfg_we && (cfg.cfg_addr == INTC_ADDR_MASK);
  assign wr_pend     = cfg.cfg_we && (cfg.cfg_addr == INTC_ADDR_PEND);
  assign wr_stat     = cfg.cfg_we && (cfg.cfg_addr == INTC_ADDR_STAT);
  assign issue_go    = (state == ST_IDLE) && win_valid && !int_en_n && inst_boundary;
  assign cnt_nx      = cnt + 1'b1;
  assign timeout_hit = (state == ST_WAIT_ACK) && !int_en_n &&
                       (cnt_nx == INTC_CNT_W'(ACK_TIMEOUT));
  assign pend_clr    = (wr_pend  ? cfg.cfg_wdata[N_IRQ-1:0] : '0) |
                       (issue_go ? (N_IRQ'(1) << win_id)     : '0);

  // Mask register and pending latch; a same-cycle detect beats any clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      if (wr_mask) mask <= cfg.cfg_wdata[N_IRQ-1:0];
      pending <= (pending & ~pend_clr) | detect;
    end
  end

  // Entry/return sequencer with ack timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      irq_vec <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_go) begin
            state   <= ST_ISSUE;
            irq_vec <= win_id;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_ACK;
          cnt   <= '0;
        end
        ST_WAIT_ACK: begin
          if (int_en_n)         state <= ST_SERVICE;
          else if (timeout_hit) state <= ST_IDLE;
          else                  cnt   <= cnt_nx;
        end
        ST_SERVICE: begin
          if (!int_en_n) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky ack-timeout flag; a new timeout beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          timeout_flag <= 1'b0;
    else if (timeout_hit)                timeout_flag <= 1'b1;
    else if (wr_stat && cfg.cfg_wdata[0]) timeout_flag <= 1'b0;
  end

  // set_intr and irq_active decode straight from state so reset cuts them at once.
  assign set_intr   = (state == ST_ISSUE);
  assign irq_active = (state != ST_IDLE);

  // Combinational config read mux.
  always_comb begin
    cfg.cfg_rdata = '0;
    case (cfg.cfg_addr)
      INTC_ADDR_MASK: cfg.cfg_rdata = 32'(mask);
      INTC_ADDR_PEND: cfg.cfg_rdata = 32'(pending);
      INTC_ADDR_ID:   cfg.cfg_rdata = 32'(irq_vec);
      INTC_ADDR_STAT: cfg.cfg_rdata = {23'd0, |eligible, 3'd0, 3'(state), irq_active, timeout_flag};
      default:        cfg.cfg_rdata = '0;
    endcase
  end

endmodule
